qspi_flash_reader: RTL
======================

Name: qspi_flash_reader

Overview:
Synthesizable QSPI initiator that issues Quad Output Fast Read (0x6B) transactions to the board SPI flash and streams the returned bytes to the core or a loader. It is the master end of the link served by SimSpiFlashModel in simulation. It generates SCK itself with a prescaler, so the sim-only clock generator is no longer needed.

Parameters:
PRESCALER, 4, SCK half-period in clock cycles minus 1 (SCK period = 2*(PRESCALER+1) clocks); legal range 0..15.
DUMMY_CYCLES, 6, SCK cycles between the last address bit and the first data nibble.
CS_HIGH_CYCLES, 4, minimum clocks CS stays high between transactions.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
io_req_valid  in  1  read request valid
io_req_ready  out  1  high only in IDLE
io_req_addr  in  24  flash byte address
io_req_len  in  12  byte count minus 1 (1..4096 bytes)
io_resp_valid  out  1  data byte valid
io_resp_ready  in  1  consumer ready
io_resp_data  out  8  data byte
io_resp_last  out  1  marks the final byte of the request
io_busy  out  1  high whenever state != IDLE
io_qspi_cs  out  1  chip select, active low
io_qspi_sck  out  1  serial clock, mode 0 (idles low)
io_qspi_dq_o  out  4  dq output values
io_qspi_dq_oe  out  4  dq output enables; only bit 0 is ever used
io_qspi_dq_i  in  4  dq sampled inputs

Behaviour:
- Reset values: cs=1, sck=0, dq_o=0, dq_oe=0, resp_valid=0, resp_last=0, req_ready=0 during reset then 1, busy=0. State returns to IDLE. Reset mid-transaction forces cs high on the next edge and drops any pending response byte.
- Tick: the divider counter counts 0..PRESCALER and pulses tick on wrap. Each tick toggles sck while in CMD/ADDR/DUMMY/DATA. A rise tick is 0->1; a fall tick is 1->0.
- Rise tick: the flash samples dq0; the reader samples dq_i. Fall tick: the reader shifts the next output bit.
- IDLE: on req_valid && req_ready, latch addr and len. Load shifter = {8'h6B, addr}, counter cleared. Drive cs=0, dq_oe=4'b0001, dq_o[0]=shifter MSB. Go to CMD. The first rise tick follows PRESCALER+1 clocks later, giving half a period of CS setup.
- CMD: 8 rising edges, MSB first on dq0. The fall tick after the 8th rise goes to ADDR.
- ADDR: 24 rising edges, addr[23] first. The fall tick after the last rise sets dq_oe=0 and goes to DUMMY.
- DUMMY: DUMMY_CYCLES rising edges, nothing sampled. Go to DATA at the following fall tick.
- DATA: each rise tick shifts dq_i[3:0] into the byte assembler, high nibble first. After 2 rises the byte is complete and is copied to resp_data with resp_valid=1 on the next clock. resp_last=1 when the remaining count is 0.
- Backpressure: if resp_valid && !resp_ready when the next byte's first rise tick is due, hold sck low and freeze the divider. This is legal in mode 0. A response transfer fires on resp_valid && resp_ready.
- At most one byte is buffered. Throughput is 1 byte per SCK period pair when the consumer is always ready.
- After the last byte is assembled (the fall tick after its 2nd rise), go to DONE: sck=0, cs=1.
- DONE: wait until CS_HIGH_CYCLES have elapsed and the last byte has been accepted, then return to IDLE.
- Address wrap: no bound check. The flash wraps internally; the reader just counts bytes.
- A req_valid during a transaction is ignored (req_ready=0).

Decomposition:
- Package qspi_pkg holds:
  - state enum {IDLE, CMD, ADDR, DUMMY, DATA, DONE}
  - QSPI_CMD_QUAD_OUT_READ = 8'h6B
  - ADDR_BITS = 24
  - CMD_BITS = 8
- One sub-module: qspi_sck_divider, with inputs clock, reset, run and hold, and outputs tick, rise and sck. It contains the prescaler counter and the sck flop.
- The FSM, shifter and byte assembler stay in the top module.

Test Plan:
- Basic read: flash byte[a]=a[7:0], PRESCALER=4, req addr 0x000010 len 3. Response is 0x10,0x11,0x12,0x13 with last on 0x13. Exactly 46 sck rising edges, sck period 10 clocks. Dq0 carries 0x6B then 0x000010 on the first 32 rises. Cs is high again ≥4 clocks before req_ready.
- Backpressure: same request with resp_ready low for 50 clocks after the 1st byte. Sck stays low during the stall, cs stays low, bytes stay in order, and no byte is lost or duplicated.
- Single byte plus back-to-back: len=0 at 0x000FFF returns 0xFF with last=1. A second request issued the same cycle as req_ready rises sees cs held high for ≥CS_HIGH_CYCLES before going low.
- Reset mid-DATA: assert reset for 1 clock after the 2nd byte. Next clock shows cs=1, sck=0, resp_valid=0, req_ready=1. A new read at 0x000020 len 1 returns 0x20,0x21.
- PRESCALER=0, DUMMY_CYCLES=8: read len 7 at 0x000100 returns 0x00..0x07. Sck period is 2 clocks, and the first nibble is sampled on rise 41.
- Request ignored while busy: pulse req_valid during ADDR. req_ready stays 0 and the transaction is unaffected.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI quad-output flash reader.
// Contents: transaction state encoding, flash opcode, and the bit lengths of
// the command and address phases.
package qspi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CMD   = 3'd1,
      ADDR  = 3'd2,
      DUMMY = 3'd3,
      DATA  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [7:0] QSPI_CMD_QUAD_OUT_READ = 8'h6B;
   localparam int ADDR_BITS = 24;
   localparam int CMD_BITS  = 8;

endpackage

// File: rtl/qspi_sck_divider.sv
// SCK generator for the QSPI reader.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   run          : high while a transaction is clocking; low forces sck=0
//   hold         : freezes the prescaler and sck (consumer backpressure)
//   tick         : one-clock pulse on every sck toggle
//   rise         : tick that takes sck 0->1 (flash and reader sample here)
//   sck          : registered serial clock, idles low (mode 0)
module qspi_sck_divider #(
   parameter int PRESCALER = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   input  logic hold,
   output logic tick,
   output logic rise,
   output logic sck
);

   logic [3:0] cnt_reg;
   logic       sck_reg;

   assign tick = run && !hold && (cnt_reg == 4'(PRESCALER));
   assign rise = tick && !sck_reg;
   assign sck  = sck_reg;

   always_ff @(posedge clock) begin
      if (reset || !run) begin
         cnt_reg <= '0;
         sck_reg <= 1'b0;
      end else if (!hold) begin
         if (tick) begin
            cnt_reg <= '0;
            sck_reg <= !sck_reg;
         end else begin
            cnt_reg <= cnt_reg + 4'd1;
         end
      end
   end

endmodule

// File: rtl/qspi_flash_reader.sv
// QSPI initiator issuing Quad Output Fast Read (0x6B) and streaming bytes out.
// Ports:
//   clock, reset       : system clock, synchronous active-high reset
//   io_req_*           : read request (24-bit byte address, length-1)
//   io_resp_*          : one-deep byte stream, last marks the final byte
//   io_busy            : high outside IDLE
//   io_qspi_*          : flash pins (cs active low, sck mode 0, 4-bit dq)
module qspi_flash_reader
   import qspi_pkg::*;
#(
   parameter int PRESCALER      = 4,
   parameter int DUMMY_CYCLES   = 6,
   parameter int CS_HIGH_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_req_valid,
   output logic        io_req_ready,
   input  logic [23:0] io_req_addr,
   input  logic [11:0] io_req_len,
   output logic        io_resp_valid,
   input  logic        io_resp_ready,
   output logic [7:0]  io_resp_data,
   output logic        io_resp_last,
   output logic        io_busy,
   output logic        io_qspi_cs,
   output logic        io_qspi_sck,
   output logic [3:0]  io_qspi_dq_o,
   output logic [3:0]  io_qspi_dq_oe,
   input  logic [3:0]  io_qspi_dq_i
);

   state_t      state_reg;
   logic        cs_reg;
   logic [3:0]  oe_reg;
   logic [31:0] shifter_reg;
   logic [7:0]  bit_cnt_reg;
   logic        nib_reg;
   logic [3:0]  hi_nib_reg;
   logic [11:0] rem_reg;
   logic        fin_reg;
   logic        resp_valid_reg;
   logic        resp_last_reg;
   logic [7:0]  resp_data_reg;
   logic [15:0] cs_cnt_reg;

   logic run, hold, tick, rise, fall, sck;

   assign run  = (state_reg != IDLE) && (state_reg != DONE);
   // Stall only while sck is low and the next rise would start a new byte
   // with the single output slot still occupied.
   assign hold = (state_reg == DATA) && !sck && !nib_reg &&
                 resp_valid_reg && !io_resp_ready;
   assign fall = tick && sck;

   qspi_sck_divider #(.PRESCALER(PRESCALER)) u_div (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .hold  (hold),
      .tick  (tick),
      .rise  (rise),
      .sck   (sck)
   );

   assign io_req_ready  = (state_reg == IDLE) && !reset;
   assign io_busy       = (state_reg != IDLE);
   assign io_resp_valid = resp_valid_reg;
   assign io_resp_data  = resp_data_reg;
   assign io_resp_last  = resp_last_reg;
   assign io_qspi_cs    = cs_reg;
   assign io_qspi_sck   = sck;
   assign io_qspi_dq_o  = {3'b000, shifter_reg[31]};
   assign io_qspi_dq_oe = oe_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         cs_reg         <= 1'b1;
         oe_reg         <= 4'b0000;
         shifter_reg    <= '0;
         bit_cnt_reg    <= '0;
         nib_reg        <= 1'b0;
         hi_nib_reg     <= '0;
         rem_reg        <= '0;
         fin_reg        <= 1'b0;
         resp_valid_reg <= 1'b0;
         resp_last_reg  <= 1'b0;
         resp_data_reg  <= '0;
         cs_cnt_reg     <= '0;
      end else begin
         if (resp_valid_reg && io_resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_last_reg  <= 1'b0;
         end
         unique case (state_reg)
            IDLE: begin
               if (io_req_valid) begin
                  shifter_reg <= {QSPI_CMD_QUAD_OUT_READ, io_req_addr};
                  rem_reg     <= io_req_len;
                  bit_cnt_reg <= '0;
                  nib_reg     <= 1'b0;
                  fin_reg     <= 1'b0;
                  cs_reg      <= 1'b0;
                  oe_reg      <= 4'b0001;
                  state_reg   <= CMD;
               end
            end
            CMD, ADDR: begin
               // One counter spans both phases; the flash samples on rise,
               // the next bit is presented on the following fall.
               if (rise) bit_cnt_reg <= bit_cnt_reg + 8'd1;
               if (fall) begin
                  shifter_reg <= {shifter_reg[30:0], 1'b0};
                  if (state_reg == CMD && bit_cnt_reg == 8'(CMD_BITS)) begin
                     state_reg <= ADDR;
                  end
                  if (state_reg == ADDR && bit_cnt_reg == 8'(CMD_BITS + ADDR_BITS)) begin
                     oe_reg      <= 4'b0000;
                     bit_cnt_reg <= '0;
                     state_reg   <= DUMMY;
                  end
               end
            end
            DUMMY: begin
               if (rise) bit_cnt_reg <= bit_cnt_reg + 8'd1;
               if (fall && bit_cnt_reg == 8'(DUMMY_CYCLES)) begin
                  bit_cnt_reg <= '0;
                  state_reg   <= DATA;
               end
            end
            DATA: begin
               if (rise) begin
                  if (!nib_reg) begin
                     hi_nib_reg <= io_qspi_dq_i;
                     nib_reg    <= 1'b1;
                  end else begin
                     resp_data_reg  <= {hi_nib_reg, io_qspi_dq_i};
                     resp_valid_reg <= 1'b1;
                     resp_last_reg  <= (rem_reg == 12'd0);
                     fin_reg        <= (rem_reg == 12'd0);
                     rem_reg        <= rem_reg - 12'd1;
                     nib_reg        <= 1'b0;
                  end
               end
               if (fall && fin_reg) begin
                  cs_reg     <= 1'b1;
                  cs_cnt_reg <= '0;
                  state_reg  <= DONE;
               end
            end
            DONE: begin
               if (cs_cnt_reg != 16'hFFFF) cs_cnt_reg <= cs_cnt_reg + 16'd1;
               if (cs_cnt_reg >= 16'(CS_HIGH_CYCLES - 1) &&
                   (!resp_valid_reg || io_resp_ready)) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
